alu_cmd_queue: RTL and testbench

Command buffer and result stage wrapped around the 4-bit combinational `alu` (a, b, sel -> out, carry_out).
- Upstream: a producer pushes (a, b, sel) commands through a valid/ready handshake into a FIFO.
- The FIFO head drives the ALU inputs directly.
- The ALU output is captured into a result register that a downstream consumer drains through a second valid/ready handshake.
- The ALU is instantiated externally; this block drives its inputs and samples its outputs.

---
 rtl/alu_cmd_queue.sv | 102 ++++++++++
 tb/tb_alu_cmd_queue.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_queue.sv
// Command FIFO feeding an external combinational ALU, with a registered result
// stage drained by a valid/ready consumer.
module alu_cmd_queue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_a,
  input  logic [WIDTH-1:0]           in_b,
  input  logic [1:0]                 in_sel,
  output logic [WIDTH-1:0]           alu_a,
  output logic [WIDTH-1:0]           alu_b,
  output logic [1:0]                 alu_sel,
  input  logic [WIDTH-1:0]           alu_out,
  input  logic                       alu_carry,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [WIDTH-1:0]           res_out,
  output logic                       res_carry,
  output logic [$clog2(DEPTH):0]     count,
  output logic [7:0]                 ops_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {EMPTY, FULL} res_state_t;

  logic [WIDTH-1:0] mem_a   [DEPTH];
  logic [WIDTH-1:0] mem_b   [DEPTH];
  logic [1:0]       mem_sel [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count_q;
  logic          push, pop, deliver, nonempty;
  res_state_t    state, state_next;

  assign nonempty = (count_q != '0);
  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid & in_ready;
  assign pop      = nonempty & (~res_valid | res_ready);
  assign deliver  = res_valid & res_ready;
  assign count    = count_q;

  // Head drives the ALU directly; zeros when empty so the ALU sees a quiet bus.
  assign alu_a   = nonempty ? mem_a[rd_ptr]   : '0;
  assign alu_b   = nonempty ? mem_b[rd_ptr]   : '0;
  assign alu_sel = nonempty ? mem_sel[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      EMPTY: if (pop) state_next = FULL;
      FULL:  if (!pop && res_ready) state_next = EMPTY;
      default: state_next = EMPTY;
    endcase
  end

  always_comb begin
    res_valid = (state == FULL);
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= in_a;
      mem_b[wr_ptr]   <= in_b;
      mem_sel[wr_ptr] <= in_sel;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      res_out   <= '0;
      res_carry <= 1'b0;
      ops_done  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        res_out   <= alu_out;
        res_carry <= alu_carry;
      end
      count_q <= count_q + CW'(push) - CW'(pop);
      if (deliver) ops_done <= ops_done + 8'd1;
    end
  end

endmodule

// File: tb/tb_alu_cmd_queue.sv
// Self-checking bench: queue-based reference model of the command buffer and
// result stage, a stand-in ALU, directed literal checks and a random run.
module tb_alu_cmd_queue;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0, in_b = '0;
  logic [1:0] in_sel = '0;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [1:0] alu_sel;
  logic       alu_carry;
  logic       res_valid;
  logic       res_ready = 1'b0;
  logic [3:0] res_out;
  logic       res_carry;
  logic [2:0] count;
  logic [7:0] ops_done;

  int npass = 0;
  int ntotal = 0;

  always #5 clk = ~clk;

  alu_cmd_queue #(.WIDTH(4), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_out(res_out), .res_carry(res_carry),
    .count(count), .ops_done(ops_done)
  );

  function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] s);
    case (s)
      2'b00:   return {1'b0, a & b};
      2'b01:   return {1'b0, a | b};
      2'b10:   return {1'b0, a ^ b};
      default: return {1'b0, a} + {1'b0, b};
    endcase
  endfunction

  // Stand-in for the external alu instance.
  always_comb {alu_carry, alu_out} = ref_alu(alu_a, alu_b, alu_sel);

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] s;
  } cmd_t;

  cmd_t       mq[$];
  logic       m_rv = 1'b0;
  logic [3:0] m_out = '0;
  logic       m_c = 1'b0;
  logic [7:0] m_ops = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: advances on each rising edge from the inputs presented.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_rv  <= 1'b0;
      m_out <= '0;
      m_c   <= 1'b0;
      m_ops <= '0;
    end else begin
      automatic bit    do_push = in_valid && (mq.size() < DEPTH);
      automatic bit    do_pop  = (mq.size() > 0) && (!m_rv || res_ready);
      automatic cmd_t  h;
      automatic logic [4:0] r;
      if (m_rv && res_ready) m_ops <= m_ops + 8'd1;
      if (do_pop) begin
        h = mq.pop_front();
        r = ref_alu(h.a, h.b, h.s);
        m_out <= r[3:0];
        m_c   <= r[4];
        m_rv  <= 1'b1;
      end else if (m_rv && res_ready) begin
        m_rv <= 1'b0;
      end
      if (do_push) mq.push_back('{a: in_a, b: in_b, s: in_sel});
    end
  end

  always @(negedge clk) begin
    automatic cmd_t hd = (mq.size() > 0) ? mq[0] : '0;
    chk("in_ready",  32'(in_ready),  32'(mq.size() < DEPTH));
    chk("count",     32'(count),     32'(mq.size()));
    chk("alu_a",     32'(alu_a),     32'(hd.a));
    chk("alu_b",     32'(alu_b),     32'(hd.b));
    chk("alu_sel",   32'(alu_sel),   32'(hd.s));
    chk("res_valid", 32'(res_valid), 32'(m_rv));
    chk("res_out",   32'(res_out),   32'(m_out));
    chk("res_carry", 32'(res_carry), 32'(m_c));
    chk("ops_done",  32'(ops_done),  32'(m_ops));
  end

  task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] s, input logic rr, input logic r);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_sel    = s;
    res_ready = rr;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    step(1'b0, 4'd0, 4'd0, 2'd0, rr, 1'b0);
  endtask

  initial begin
    int rr_pct;
    step(1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b1);
    idle(1'b1);
    chk("lit_reset_count", 32'(count), 32'd0);
    chk("lit_reset_valid", 32'(res_valid), 32'd0);
    chk("lit_reset_ready", 32'(in_ready), 32'd1);
    chk("lit_reset_ops",   32'(ops_done), 32'd0);

    // single ADD 3+1
    step(1'b1, 4'b0011, 4'b0001, 2'b11, 1'b1, 1'b0);
    chk("lit_add_count", 32'(count), 32'd1);
    chk("lit_add_alu_a", 32'(alu_a), 32'd3);
    idle(1'b1);
    chk("lit_add_valid", 32'(res_valid), 32'd1);
    chk("lit_add_out",   32'(res_out), 32'b0100);
    chk("lit_add_carry", 32'(res_carry), 32'd0);
    idle(1'b1);
    chk("lit_add_ops", 32'(ops_done), 32'd1);

    // carry and ordering, back to back
    step(1'b1, 4'b1111, 4'b0001, 2'b11, 1'b1, 1'b0);
    step(1'b1, 4'b0100, 4'b0010, 2'b00, 1'b1, 1'b0);
    chk("lit_seq_add_out",   32'(res_out), 32'b0000);
    chk("lit_seq_add_carry", 32'(res_carry), 32'd1);
    step(1'b1, 4'b1100, 4'b1010, 2'b01, 1'b1, 1'b0);
    chk("lit_seq_and_out", 32'(res_out), 32'b0000);
    step(1'b1, 4'b1100, 4'b1010, 2'b10, 1'b1, 1'b0);
    chk("lit_seq_or_out", 32'(res_out), 32'b1110);
    idle(1'b1);
    chk("lit_seq_xor_out", 32'(res_out), 32'b0110);
    chk("lit_seq_ops", 32'(ops_done), 32'd4);
    idle(1'b1);
    chk("lit_seq_ops_end", 32'(ops_done), 32'd5);

    // backpressure up to full, first command 9+9 sits in the result register
    step(1'b1, 4'd9, 4'd9, 2'b11, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 1), 4'(2 * i), 2'(i), 1'b0, 1'b0);
    chk("lit_full_count", 32'(count), 32'd4);
    chk("lit_full_ready", 32'(in_ready), 32'd0);
    step(1'b1, 4'd7, 4'd5, 2'b11, 1'b0, 1'b0);
    chk("lit_full_hold_count", 32'(count), 32'd4);
    chk("lit_full_hold_out",   32'(res_out), 32'b0010);
    chk("lit_full_hold_carry", 32'(res_carry), 32'd1);
    step(1'b1, 4'd7, 4'd5, 2'b11, 1'b1, 1'b0);
    chk("lit_full_refused", 32'(count), 32'd3);
    step(1'b1, 4'd7, 4'd5, 2'b11, 1'b1, 1'b0);
    chk("lit_full_accept", 32'(count), 32'd3);
    for (int i = 0; i < 6; i++) idle(1'b1);
    chk("lit_drain_count", 32'(count), 32'd0);
    chk("lit_drain_ops",   32'(ops_done), 32'd11);

    // reset mid-operation
    for (int i = 0; i < 4; i++) step(1'b1, 4'(i + 8), 4'(i), 2'b11, 1'b0, 1'b0);
    chk("lit_mid_count", 32'(count), 32'd3);
    step(1'b0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b1);
    chk("lit_rst_count", 32'(count), 32'd0);
    chk("lit_rst_valid", 32'(res_valid), 32'd0);
    chk("lit_rst_ops",   32'(ops_done), 32'd0);
    chk("lit_rst_alu",   32'({alu_a, alu_b, alu_sel}), 32'd0);
    idle(1'b1);
    idle(1'b1);
    chk("lit_rst_no_ghost", 32'(res_valid), 32'd0);

    // randomized traffic with varying consumer pressure and rare resets
    for (int i = 0; i < 2500; i++) begin
      if (i % 200 == 0) rr_pct = int'($urandom_range(10, 100));
      step($urandom_range(0, 3) != 0, 4'($urandom), 4'($urandom), 2'($urandom),
           int'($urandom_range(1, 100)) <= rr_pct, $urandom_range(0, 399) == 0);
    end

    // delivery counter wrap
    step(1'b0, 4'd0, 4'd0, 2'd0, 1'b1, 1'b1);
    for (int i = 0; i < 258; i++)
      step(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b1, 1'b0);
    chk("lit_wrap_zero", 32'(ops_done), 32'd0);
    step(1'b1, 4'($urandom), 4'($urandom), 2'($urandom), 1'b1, 1'b0);
    chk("lit_wrap_one", 32'(ops_done), 32'd1);

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
